// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: owns the state register and drives datapath strobes.
// Handles bus wait-request stalls, a timed MULT/DIV wait, sub-word byte lanes and HALT.
module mips_control_fsm #(
    parameter int BE_WIDTH      = 4,
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                waitrequest,
    input  logic                halt_req,
    input  logic [5:0]          opcode,
    input  logic [5:0]          func_code,
    input  logic [4:0]          rt_code,
    input  logic [1:0]          addr_lsb,
    output logic [2:0]          state,
    output logic                active,
    output logic                pc_write,
    output logic                ir_write,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic [BE_WIDTH-1:0] byteenable,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                hilo_write
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEMORY  = 3'd3,
        S_WBACK   = 3'd4,
        S_MULDIV  = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt;

    logic is_load;
    logic is_store;
    logic is_alu;
    logic is_hilo;
    logic is_jump;
    logic is_muldiv;
    logic is_byte;
    logic is_half;
    logic is_known;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_alu    = 1'b0;
        is_hilo   = 1'b0;
        is_jump   = 1'b0;
        is_muldiv = 1'b0;
        case (opcode)
            6'h00: begin
                case (func_code)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h10, 6'h12, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b:
                        is_alu = 1'b1;
                    6'h11, 6'h13:
                        is_hilo = 1'b1;
                    6'h08, 6'h09:
                        is_jump = 1'b1;
                    6'h18, 6'h19, 6'h1a, 6'h1b:
                        is_muldiv = 1'b1;
                    default: ;
                endcase
            end
            // REGIMM branches are distinguished by the rt field
            6'h01: begin
                case (rt_code)
                    5'h00, 5'h01, 5'h10, 5'h11: is_jump = 1'b1;
                    default: ;
                endcase
            end
            6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07:
                is_jump = 1'b1;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f:
                is_alu = 1'b1;
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26:
                is_load = 1'b1;
            6'h28, 6'h29, 6'h2b:
                is_store = 1'b1;
            default: ;
        endcase
    end

    assign is_byte  = (opcode == 6'h20) || (opcode == 6'h24)
                   || (opcode == 6'h28);
    assign is_half  = (opcode == 6'h21) || (opcode == 6'h25)
                   || (opcode == 6'h29);
    assign is_known = is_load | is_store | is_alu | is_hilo
                    | is_jump | is_muldiv;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_reg == S_EXECUTE && is_muldiv) begin
            cnt <= CNT_WIDTH'(MULDIV_CYCLES - 1);
        end else if (state_reg == S_MULDIV && cnt != '0) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        active     = 1'b1;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        byteenable = {BE_WIDTH{1'b1}};
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        hilo_write = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (halt_req) begin
                    state_next = S_HALT;
                end else begin
                    mem_read = 1'b1;
                    if (!waitrequest) begin
                        pc_write   = 1'b1;
                        state_next = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                ir_write   = 1'b1;
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_muldiv) begin
                    state_next = S_MULDIV;
                end else if (is_known) begin
                    state_next = S_MEMORY;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MULDIV: begin
                if (cnt == '0) begin
                    hilo_write = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEMORY: begin
                if (is_load || is_store) begin
                    iord      = 1'b1;
                    mem_read  = is_load;
                    mem_write = is_store;
                    if (is_byte) begin
                        byteenable = BE_WIDTH'(1) << addr_lsb;
                    end else if (is_half) begin
                        byteenable = BE_WIDTH'(3) << {addr_lsb[1], 1'b0};
                    end
                    if (!waitrequest) begin
                        state_next = is_load ? S_WBACK : S_FETCH;
                    end
                end else begin
                    reg_write  = is_alu;
                    hilo_write = is_hilo;
                    state_next = S_FETCH;
                end
            end
            S_WBACK: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                active = 1'b0;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
        // Reset aborts any access in flight: strobes drop this cycle
        if (reset) begin
            state_next = S_FETCH;
            active     = 1'b1;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            byteenable = {BE_WIDTH{1'b1}};
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            hilo_write = 1'b0;
        end
    end

    assign state = state_reg;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm with MULDIV_CYCLES=4.
// Output vector: {state,active,pc_w,ir_w,iord,mrd,mwr,be[3:0],reg_w,m2r,hilo_w}.
module tb_mips_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       waitrequest;
    logic       halt_req;
    logic [5:0] opcode;
    logic [5:0] func_code;
    logic [4:0] rt_code;
    logic [1:0] addr_lsb;
    logic [2:0] state;
    logic       active;
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] byteenable;
    logic       reg_write;
    logic       mem_to_reg;
    logic       hilo_write;
    logic [15:0] obs;

    int n_chk = 0;
    int n_err = 0;

    mips_control_fsm #(
        .BE_WIDTH(4),
        .MULDIV_CYCLES(4),
        .CNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .waitrequest(waitrequest),
        .halt_req(halt_req),
        .opcode(opcode),
        .func_code(func_code),
        .rt_code(rt_code),
        .addr_lsb(addr_lsb),
        .state(state),
        .active(active),
        .pc_write(pc_write),
        .ir_write(ir_write),
        .iord(iord),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .byteenable(byteenable),
        .reg_write(reg_write),
        .mem_to_reg(mem_to_reg),
        .hilo_write(hilo_write)
    );

    always #5 clk = ~clk;

    assign obs = {state, active, pc_write, ir_write, iord, mem_read,
                  mem_write, byteenable, reg_write, mem_to_reg, hilo_write};

    function automatic logic [15:0] pk(
        input logic [2:0] s, input logic a, input logic pw,
        input logic iw, input logic io, input logic mr, input logic mw,
        input logic [3:0] be, input logic rw, input logic m2r,
        input logic hw);
        return {s, a, pw, iw, io, mr, mw, be, rw, m2r, hw};
    endfunction

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Fetch (no stall), decode and execute of one instruction
    task automatic front(input string tag, input logic [5:0] op,
                         input logic [5:0] fn);
        opcode      = op;
        func_code   = fn;
        halt_req    = 1'b0;
        waitrequest = 1'b0;
        #1;
        check({tag, "_fetch"}, obs, pk(0,1,1,0,0,1,0,4'hf,0,0,0));
        tick();
        check({tag, "_decode"}, obs, pk(1,1,0,1,0,0,0,4'hf,0,0,0));
        tick();
        check({tag, "_exec"}, obs, pk(2,1,0,0,0,0,0,4'hf,0,0,0));
        tick();
    endtask

    task automatic muldiv_run(input string tag, input logic [5:0] fn);
        front(tag, 6'h00, fn);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_wait"}, obs, pk(5,1,0,0,0,0,0,4'hf,0,0,0));
            tick();
        end
        check({tag, "_last"}, obs, pk(5,1,0,0,0,0,0,4'hf,0,0,1));
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        waitrequest = 1'b0;
        halt_req    = 1'b0;
        opcode      = 6'h00;
        func_code   = 6'h00;
        rt_code     = 5'h00;
        addr_lsb    = 2'd0;
        tick();
        check("reset", obs, pk(0,1,0,0,0,0,0,4'hf,0,0,0));
        reset = 1'b0;

        // ADDIU
        front("addiu", 6'h09, 6'h00);
        check("addiu_mem", obs, pk(3,1,0,0,0,0,0,4'hf,1,0,0));
        tick();

        // LW with 3 fetch stalls and 2 memory stalls
        opcode      = 6'h23;
        waitrequest = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("lw_fstall", obs, pk(0,1,0,0,0,1,0,4'hf,0,0,0));
            tick();
        end
        waitrequest = 1'b0;
        #1;
        check("lw_fetch", obs, pk(0,1,1,0,0,1,0,4'hf,0,0,0));
        tick();
        waitrequest = 1'b1;
        #1;
        check("lw_decode", obs, pk(1,1,0,1,0,0,0,4'hf,0,0,0));
        tick();
        check("lw_exec", obs, pk(2,1,0,0,0,0,0,4'hf,0,0,0));
        tick();
        for (int i = 0; i < 2; i++) begin
            check("lw_mstall", obs, pk(3,1,0,0,1,1,0,4'hf,0,0,0));
            tick();
        end
        waitrequest = 1'b0;
        #1;
        check("lw_mem", obs, pk(3,1,0,0,1,1,0,4'hf,0,0,0));
        tick();
        check("lw_wb", obs, pk(4,1,0,0,0,0,0,4'hf,1,1,0));
        tick();

        // SB at lane 3
        addr_lsb = 2'd3;
        front("sb", 6'h28, 6'h00);
        check("sb_mem", obs, pk(3,1,0,0,1,0,1,4'b1000,0,0,0));
        tick();

        // SH at upper half
        addr_lsb = 2'd2;
        front("sh", 6'h29, 6'h00);
        check("sh_mem", obs, pk(3,1,0,0,1,0,1,4'b1100,0,0,0));
        tick();

        // LB at lane 1
        addr_lsb = 2'd1;
        front("lb", 6'h20, 6'h00);
        check("lb_mem", obs, pk(3,1,0,0,1,1,0,4'b0010,0,0,0));
        tick();
        check("lb_wb", obs, pk(4,1,0,0,0,0,0,4'hf,1,1,0));
        tick();

        // LHU at lower half
        addr_lsb = 2'd0;
        front("lhu", 6'h25, 6'h00);
        check("lhu_mem", obs, pk(3,1,0,0,1,1,0,4'b0011,0,0,0));
        tick();
        check("lhu_wb", obs, pk(4,1,0,0,0,0,0,4'hf,1,1,0));
        tick();

        // LWL with unaligned address stays full-word
        addr_lsb = 2'd1;
        front("lwl", 6'h22, 6'h00);
        check("lwl_mem", obs, pk(3,1,0,0,1,1,0,4'hf,0,0,0));
        tick();
        tick();

        // MTHI writes HI only
        front("mthi", 6'h00, 6'h11);
        check("mthi_mem", obs, pk(3,1,0,0,0,0,0,4'hf,0,0,1));
        tick();

        // BEQ: one memory-stage cycle, no writes
        front("beq", 6'h04, 6'h00);
        check("beq_mem", obs, pk(3,1,0,0,0,0,0,4'hf,0,0,0));
        tick();

        // Unrecognised opcode falls back to FETCH from EXECUTE
        front("bad", 6'h3f, 6'h00);

        // MULT: exactly 4 wait cycles
        muldiv_run("mult", 6'h18);

        // DIV aborted by reset in the second wait cycle
        front("div", 6'h00, 6'h1a);
        check("div_w1", obs, pk(5,1,0,0,0,0,0,4'hf,0,0,0));
        tick();
        reset = 1'b1;
        #1;
        check("div_rst", obs, pk(5,1,0,0,0,0,0,4'hf,0,0,0));
        tick();
        check("div_rst_fetch", obs, pk(0,1,0,0,0,0,0,4'hf,0,0,0));
        reset = 1'b0;

        // Counter reloads fully after the abort
        muldiv_run("multu", 6'h19);

        // HALT entry, hold, and exit by reset
        halt_req = 1'b1;
        #1;
        check("halt_fetch", obs, pk(0,1,0,0,0,0,0,4'hf,0,0,0));
        tick();
        halt_req    = 1'b0;
        waitrequest = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("halt_hold", obs, pk(6,0,0,0,0,0,0,4'hf,0,0,0));
            tick();
        end
        reset = 1'b1;
        #1;
        check("halt_rst", obs, pk(6,1,0,0,0,0,0,4'hf,0,0,0));
        tick();
        check("halt_rst_fetch", obs, pk(0,1,0,0,0,0,0,4'hf,0,0,0));
        reset       = 1'b0;
        waitrequest = 1'b0;
        #1;
        check("post_halt", obs, pk(0,1,1,0,0,1,0,4'hf,0,0,0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
